// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared player, fire state and coordinate types for the tank game
package tank_pkg;

    typedef enum logic {
        PLAYER_L = 1'b0,
        PLAYER_R = 1'b1
    } player_e;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_e;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/fire_cooldown.sv
// rtl/fire_cooldown.sv - one player's ready/pending/cooldown sequence with fire key edge detect
// Optional: BULLET_FIRE_SCHED_AUTOFIRE_EN makes a held key request again once cooldown ends.
module fire_cooldown
    import tank_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic fire_req,
    input  logic grant,
    output logic pending
);

    fire_state_e state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        prev_req;
    logic        request;

`ifdef BULLET_FIRE_SCHED_AUTOFIRE_EN
    assign request = fire_req;
`else
    assign request = fire_req & ~prev_req;
`endif

    assign pending = (state == PENDING);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            READY: begin
                if (request) state_nxt = PENDING;
            end
            PENDING: begin
                if (grant) begin
                    state_nxt = COOLDOWN;
                    cnt_nxt   = 8'(COOLDOWN_FRAMES);
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = READY;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= READY;
            cnt      <= '0;
            prev_req <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_req <= fire_req;
        end
    end

endmodule

// File: rtl/bullet_fire_scheduler.sv
// rtl/bullet_fire_scheduler.sv - arbitrates left/right fire requests onto a pool of bullet slots
// Optional: BULLET_FIRE_SCHED_AUTOFIRE_EN (see fire_cooldown).
module bullet_fire_scheduler
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int LIFETIME_FRAMES = 120
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic [1:0]           fire_req,
    input  coord_t               l_init_x,
    input  coord_t               l_init_y,
    input  coord_t               l_motion_x,
    input  coord_t               l_motion_y,
    input  coord_t               r_init_x,
    input  coord_t               r_init_y,
    input  coord_t               r_motion_x,
    input  coord_t               r_motion_y,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic [1:0]           fire_grant,
    output logic [NUM_SLOTS-1:0] slot_load,
    output coord_t               load_x,
    output coord_t               load_y,
    output coord_t               load_mx,
    output coord_t               load_my,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner
);

    logic [1:0]           pending;
    logic                 grant_l, grant_r, any_grant, any_free;
    logic [NUM_SLOTS-1:0] alloc_oh;
    player_e              rr_ptr, grant_player;
    logic [9:0]           life [NUM_SLOTS];

    fire_cooldown #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_fire_l (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .fire_req(fire_req[0]), .grant(grant_l), .pending(pending[0])
    );

    fire_cooldown #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_fire_r (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .fire_req(fire_req[1]), .grant(grant_r), .pending(pending[1])
    );

    // Lowest-index inactive slot; slots freed this cycle are still active here.
    always_comb begin
        alloc_oh = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !any_free) begin
                alloc_oh[i] = 1'b1;
                any_free    = 1'b1;
            end
        end
    end

    assign grant_l      = any_free & pending[0] & (~pending[1] | (rr_ptr == PLAYER_L));
    assign grant_r      = any_free & pending[1] & (~pending[0] | (rr_ptr == PLAYER_R));
    assign any_grant    = grant_l | grant_r;
    assign grant_player = grant_r ? PLAYER_R : PLAYER_L;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fire_grant  <= '0;
            slot_load   <= '0;
            load_x      <= '0;
            load_y      <= '0;
            load_mx     <= '0;
            load_my     <= '0;
            slot_active <= '0;
            slot_owner  <= '0;
            rr_ptr      <= PLAYER_L;
            for (int i = 0; i < NUM_SLOTS; i++) life[i] <= '0;
        end else begin
            fire_grant <= {grant_r, grant_l};
            slot_load  <= any_grant ? alloc_oh : '0;
            if (any_grant) begin
                load_x  <= (grant_player == PLAYER_R) ? r_init_x   : l_init_x;
                load_y  <= (grant_player == PLAYER_R) ? r_init_y   : l_init_y;
                load_mx <= (grant_player == PLAYER_R) ? r_motion_x : l_motion_x;
                load_my <= (grant_player == PLAYER_R) ? r_motion_y : l_motion_y;
                rr_ptr  <= (rr_ptr == PLAYER_L) ? PLAYER_R : PLAYER_L;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (any_grant && alloc_oh[i]) begin
                    slot_active[i] <= 1'b1;
                    slot_owner[i]  <= grant_player;
                    life[i]        <= 10'(LIFETIME_FRAMES);
                end else if (slot_active[i]) begin
                    if (slot_hit[i]) begin
                        slot_active[i] <= 1'b0;
                    end else if (frame_tick) begin
                        if (life[i] == 10'd1) slot_active[i] <= 1'b0;
                        life[i] <= life[i] - 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_fire_scheduler.sv
// tb/tb_bullet_fire_scheduler.sv - directed self-checking bench for bullet_fire_scheduler
module tb_bullet_fire_scheduler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] fire_req = '0;
    logic [9:0] l_init_x = '0, l_init_y = '0, l_motion_x = '0, l_motion_y = '0;
    logic [9:0] r_init_x = '0, r_init_y = '0, r_motion_x = '0, r_motion_y = '0;
    logic [3:0] slot_hit = '0;
    logic [1:0] fire_grant;
    logic [3:0] slot_load, slot_active, slot_owner;
    logic [9:0] load_x, load_y, load_mx, load_my;

    int n_cmp = 0;
    int n_err = 0;

    bullet_fire_scheduler #(.NUM_SLOTS(4), .COOLDOWN_FRAMES(15), .LIFETIME_FRAMES(120)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire_req(fire_req),
        .l_init_x(l_init_x), .l_init_y(l_init_y), .l_motion_x(l_motion_x), .l_motion_y(l_motion_y),
        .r_init_x(r_init_x), .r_init_y(r_init_y), .r_motion_x(r_motion_x), .r_motion_y(r_motion_y),
        .slot_hit(slot_hit), .fire_grant(fire_grant), .slot_load(slot_load),
        .load_x(load_x), .load_y(load_y), .load_mx(load_mx), .load_my(load_my),
        .slot_active(slot_active), .slot_owner(slot_owner)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic press(input logic [1:0] bits);
        fire_req = bits;
        step();
        fire_req = 2'b00;
    endtask

    task automatic do_reset();
        Reset      = 1'b0;
        fire_req   = 2'b00;
        frame_tick = 1'b0;
        slot_hit   = '0;
        step();
        step();
        Reset = 1'b1;
    endtask

    initial begin
        l_init_x = 10'd85;  l_init_y = 10'd40; l_motion_x = 10'd2;    l_motion_y = 10'd0;
        r_init_x = 10'd500; r_init_y = 10'd60; r_motion_x = 10'h3FE;  r_motion_y = 10'd1;

        // reset state and first left shot
        do_reset();
        check("rst_grant", 32'(fire_grant), 32'h0);
        check("rst_load", 32'(slot_load), 32'h0);
        check("rst_active", 32'(slot_active), 32'h0);
        check("rst_owner", 32'(slot_owner), 32'h0);
        check("rst_data", {load_x, load_y, load_mx[5:0], load_my[5:0]}, 32'h0);
        press(2'b01);
        check("t1_n1_grant", 32'(fire_grant), 32'h0);
        step();
        check("t1_grant", 32'(fire_grant), 32'h1);
        check("t1_load", 32'(slot_load), 32'h1);
        check("t1_x", 32'(load_x), 32'd85);
        check("t1_y", 32'(load_y), 32'd40);
        check("t1_mx", 32'(load_mx), 32'd2);
        check("t1_my", 32'(load_my), 32'd0);
        check("t1_active", 32'(slot_active), 32'h1);
        check("t1_owner0", 32'(slot_owner[0]), 32'h0);
        step();
        check("t1_pulse_grant", 32'(fire_grant), 32'h0);
        check("t1_pulse_load", 32'(slot_load), 32'h0);
        check("t1_hold_active", 32'(slot_active), 32'h1);

        // simultaneous fire, round robin
        do_reset();
        press(2'b11);
        step();
        check("t2_grant_l", 32'(fire_grant), 32'h1);
        check("t2_load_l", 32'(slot_load), 32'h1);
        step();
        check("t2_grant_r", 32'(fire_grant), 32'h2);
        check("t2_load_r", 32'(slot_load), 32'h2);
        check("t2_x_r", 32'(load_x), 32'd500);
        check("t2_mx_r", 32'(load_mx), 32'h3FE);
        check("t2_owner", 32'(slot_owner[1:0]), 32'h2);
        check("t2_active", 32'(slot_active), 32'h3);
        tick(15);
        press(2'b11);
        step();
        check("t2b_grant_l", 32'(fire_grant), 32'h1);
        check("t2b_load_l", 32'(slot_load), 32'h4);
        step();
        check("t2b_grant_r", 32'(fire_grant), 32'h2);
        check("t2b_load_r", 32'(slot_load), 32'h8);
        check("t2b_active", 32'(slot_active), 32'hF);
        check("t2b_owner", 32'(slot_owner), 32'hA);

        // pool full, then a hit frees slot 2
        tick(15);
        press(2'b01);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_full_nogrant", 32'(fire_grant), 32'h0);
        end
        slot_hit = 4'b0100;
        step();
        slot_hit = 4'b0000;
        check("t3_hit_active", 32'(slot_active), 32'hB);
        check("t3_hit_nogrant", 32'(fire_grant), 32'h0);
        step();
        check("t3_grant", 32'(fire_grant), 32'h1);
        check("t3_load", 32'(slot_load), 32'h4);
        check("t3_active", 32'(slot_active), 32'hF);
        check("t3_owner", 32'(slot_owner), 32'hA);

        // cooldown: presses at 5 and 14 ticks dropped, at 15 ticks granted
        do_reset();
        press(2'b01);
        step();
        check("t4_first", 32'(fire_grant), 32'h1);
        tick(5);
        press(2'b01);
        step();
        check("t4_at5", 32'(fire_grant), 32'h0);
        tick(9);
        press(2'b01);
        step();
        check("t4_at14", 32'(fire_grant), 32'h0);
        tick(1);
        press(2'b01);
        step();
        check("t4_at15", 32'(fire_grant), 32'h1);
        check("t4_at15_load", 32'(slot_load), 32'h2);

        // lifetime expiry
        do_reset();
        press(2'b01);
        step();
        tick(119);
        check("t5_at119", 32'(slot_active), 32'h1);
        tick(1);
        check("t5_at120", 32'(slot_active), 32'h0);

        // reset mid-operation
        do_reset();
        press(2'b11);
        step();
        tick(15);
        press(2'b01);
        step();
        check("t6_live", 32'(slot_active), 32'h7);
        press(2'b10);
        Reset = 1'b0;
        step();
        check("t6_grant", 32'(fire_grant), 32'h0);
        check("t6_load", 32'(slot_load), 32'h0);
        check("t6_active", 32'(slot_active), 32'h0);
        check("t6_owner", 32'(slot_owner), 32'h0);
        check("t6_data", {load_x, load_y, load_mx[5:0], load_my[5:0]}, 32'h0);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_after_grant", 32'(fire_grant), 32'h0);
            check("t6_after_active", 32'(slot_active), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
